// File: rtl/touch_adc_reader.sv
`default_nettype none
// ============================================================================
// touch_adc_reader
//   SPI poller for an XPT2046-class touch ADC: reads an X then a Y frame while
//   the pen is down and publishes 10-bit samples with a one-cycle ready pulse.
//   Revision: 1.0
// ============================================================================
module touch_adc_reader #(
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned POLL_CYCLES = 50000,
   parameter logic [7:0]  CMD_X       = 8'hD0,
   parameter logic [7:0]  CMD_Y       = 8'h90
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       pen_irq_n,
   input  logic       spi_miso,
   output logic       spi_sclk,
   output logic       spi_cs_n,
   output logic       spi_mosi,
   output logic [9:0] sensor_x,
   output logic [9:0] sensor_y,
   output logic       sensor_data_ready,
   output logic       busy
);

   localparam int unsigned c_DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned c_BIT_W  = $clog2(24);
   localparam int unsigned c_POLL_W = $clog2(POLL_CYCLES + 1);

   localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
   localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(23);
   localparam logic [c_POLL_W-1:0] c_POLL_LAST = c_POLL_W'(POLL_CYCLES - 1);

   localparam logic [2:0] c_S_IDLE    = 3'd0;
   localparam logic [2:0] c_S_SETUP   = 3'd1;
   localparam logic [2:0] c_S_SHIFT   = 3'd2;
   localparam logic [2:0] c_S_GAP     = 3'd3;
   localparam logic [2:0] c_S_PUBLISH = 3'd4;
   localparam logic [2:0] c_S_WAIT    = 3'd5;

   logic [2:0]          r_state;
   logic [2:0]          w_state_nxt;
   logic [c_DIV_W-1:0]  r_div;
   logic [c_BIT_W-1:0]  r_bit;
   logic [c_POLL_W-1:0] r_poll;
   logic                r_frame_y;
   logic [11:0]         r_shift;
   logic [9:0]          r_res_x;
   logic                r_pen_meta;
   logic                r_pen_sync;

   logic       r_cs_n, r_sclk, r_mosi, r_ready, r_busy;
   logic [9:0] r_x, r_y;
   logic       w_cs_n, w_sclk, w_mosi, w_ready, w_busy, w_pub;

   logic       w_div_end, w_last_bit, w_poll_end, w_go, w_capture, w_mosi_next;
   logic [7:0] w_cmd;

   assign w_div_end  = (r_div == c_DIV_LAST);
   assign w_last_bit = (r_bit == c_BIT_LAST);
   assign w_poll_end = (r_poll >= c_POLL_LAST);
   assign w_go       = enable & ~r_pen_sync;
   assign w_capture  = (r_bit >= c_BIT_W'(9)) && (r_bit <= c_BIT_W'(20));
   assign w_cmd      = r_frame_y ? CMD_Y : CMD_X;
   // Value for bit r_bit+1: command bits first, zeros after the command byte.
   assign w_mosi_next = (r_bit < c_BIT_W'(7)) ? w_cmd[3'd6 - r_bit[2:0]] : 1'b0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pen_meta <= 1'b1;
         r_pen_sync <= 1'b1;
      end else begin
         r_pen_meta <= pen_irq_n;
         r_pen_sync <= r_pen_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= c_S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_S_IDLE:    if (w_go) w_state_nxt = c_S_SETUP;
         c_S_SETUP:   if (w_div_end) w_state_nxt = c_S_SHIFT;
         c_S_SHIFT:   if (w_div_end && r_sclk && w_last_bit) w_state_nxt = c_S_GAP;
         c_S_GAP:     if (w_div_end) w_state_nxt = r_frame_y ? c_S_PUBLISH : c_S_SETUP;
         c_S_PUBLISH: w_state_nxt = c_S_WAIT;
         c_S_WAIT:    if (w_poll_end) w_state_nxt = c_S_IDLE;
         default:     w_state_nxt = c_S_IDLE;
      endcase
   end

   // Next values of the registered outputs, decided one edge ahead.
   always_comb begin
      w_cs_n  = r_cs_n;
      w_sclk  = r_sclk;
      w_mosi  = r_mosi;
      w_busy  = r_busy;
      w_ready = 1'b0;
      w_pub   = 1'b0;
      case (r_state)
         c_S_IDLE: begin
            if (w_go) begin
               w_cs_n = 1'b0;
               w_sclk = 1'b0;
               w_mosi = CMD_X[7];
               w_busy = 1'b1;
            end
         end
         c_S_SHIFT: begin
            if (w_div_end) begin
               if (!r_sclk) begin
                  w_sclk = 1'b1;
               end else begin
                  w_sclk = 1'b0;
                  w_mosi = w_last_bit ? 1'b0 : w_mosi_next;
                  if (w_last_bit) w_cs_n = 1'b1;
               end
            end
         end
         c_S_GAP: begin
            if (w_div_end) begin
               if (!r_frame_y) begin
                  w_cs_n = 1'b0;
                  w_mosi = CMD_Y[7];
               end else begin
                  w_busy  = 1'b0;
                  w_pub   = w_go;
                  w_ready = w_go;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cs_n    <= 1'b1;
         r_sclk    <= 1'b0;
         r_mosi    <= 1'b0;
         r_busy    <= 1'b0;
         r_ready   <= 1'b0;
         r_x       <= '0;
         r_y       <= '0;
         r_div     <= '0;
         r_bit     <= '0;
         r_poll    <= '0;
         r_frame_y <= 1'b0;
         r_shift   <= '0;
         r_res_x   <= '0;
      end else begin
         r_cs_n  <= w_cs_n;
         r_sclk  <= w_sclk;
         r_mosi  <= w_mosi;
         r_busy  <= w_busy;
         r_ready <= w_ready;
         if (w_pub) begin
            r_x <= r_res_x;
            r_y <= r_shift[11:2];
         end
         if ((r_state == c_S_SETUP || r_state == c_S_SHIFT || r_state == c_S_GAP) && !w_div_end)
            r_div <= r_div + c_DIV_W'(1);
         else
            r_div <= '0;
         case (r_state)
            c_S_IDLE: begin
               r_bit     <= '0;
               r_frame_y <= 1'b0;
            end
            c_S_SHIFT: begin
               if (w_div_end) begin
                  if (!r_sclk && w_capture) r_shift <= {r_shift[10:0], spi_miso};
                  if (r_sclk && !w_last_bit) r_bit <= r_bit + c_BIT_W'(1);
               end
            end
            c_S_GAP: begin
               if (w_div_end && !r_frame_y) begin
                  r_res_x   <= r_shift[11:2];
                  r_frame_y <= 1'b1;
                  r_bit     <= '0;
               end
            end
            // The PUBLISH cycle counts as the first idle cycle of the poll gap.
            c_S_PUBLISH: r_poll <= c_POLL_W'(1);
            c_S_WAIT:    if (!w_poll_end) r_poll <= r_poll + c_POLL_W'(1);
            default: ;
         endcase
      end
   end

   assign spi_cs_n          = r_cs_n;
   assign spi_sclk          = r_sclk;
   assign spi_mosi          = r_mosi;
   assign sensor_x          = r_x;
   assign sensor_y          = r_y;
   assign sensor_data_ready = r_ready;
   assign busy              = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_touch_adc_reader.sv
`default_nettype none
// ============================================================================
// tb_touch_adc_reader
//   Randomized bench: behavioural ADC slave plus sample scoreboard.
//   Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_touch_adc_reader;

   localparam int unsigned CLK_DIV = 2;
   localparam int unsigned POLL    = 100;
   localparam int LAT    = 100 * CLK_DIV;
   localparam int PERIOD = 100 * CLK_DIV + POLL + 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       pen_irq_n = 1'b1;
   logic       spi_miso = 1'b0;
   logic       spi_sclk, spi_cs_n, spi_mosi, sensor_data_ready, busy;
   logic [9:0] sensor_x, sensor_y;

   touch_adc_reader #(
      .CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL), .CMD_X(8'hD0), .CMD_Y(8'h90)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .pen_irq_n(pen_irq_n),
      .spi_miso(spi_miso), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
      .spi_mosi(spi_mosi), .sensor_x(sensor_x), .sensor_y(sensor_y),
      .sensor_data_ready(sensor_data_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ADC slave model and bus observer
   logic [23:0] adc_q[$];
   logic [23:0] pair_m;
   logic [11:0] cur_val, pend_y;
   logic [7:0]  byte_acc, last_cmd_x, last_cmd_y;
   logic [9:0]  ready_x, ready_y;
   int  k = 0, in_y = 0;
   int  last_rise_x = 0, last_rise_y = 0, last_gap = 0;
   int  t_cs_x = 0, t_rise = 0, busy_fall_cyc = 0;
   int  ready_count = 0, ready_cyc = 0, prev_ready_cyc = 0, wide_pulse = 0;
   int  cs_fall_count = 0, rise_total = 0;
   logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0, prev_ready = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         k = 0; in_y = 0;
         prev_cs = 1'b1; prev_sclk = 1'b0; prev_busy = 1'b0; prev_ready = 1'b0;
         spi_miso = 1'b0;
      end else begin
         if (prev_cs && !spi_cs_n) begin
            cs_fall_count++;
            k = 0;
            byte_acc = 8'h00;
            if (!prev_busy) begin
               in_y = 0;
               t_cs_x = cyc;
               pair_m = (adc_q.size() > 0) ? adc_q.pop_front() : 24'($urandom);
               cur_val = pair_m[23:12];
               pend_y  = pair_m[11:0];
            end else begin
               in_y = 1;
               cur_val = pend_y;
               last_gap = cyc - t_rise;
            end
         end
         if (!prev_sclk && spi_sclk) begin
            if (k < 8) byte_acc = {byte_acc[6:0], spi_mosi};
            k++;
            rise_total++;
         end
         if (!prev_cs && spi_cs_n) begin
            t_rise = cyc;
            if (in_y != 0) begin last_cmd_y = byte_acc; last_rise_y = k; end
            else           begin last_cmd_x = byte_acc; last_rise_x = k; end
         end
         if (prev_busy && !busy) busy_fall_cyc = cyc;
         if (sensor_data_ready && !prev_ready) begin
            ready_count++;
            prev_ready_cyc = ready_cyc;
            ready_cyc = cyc;
            ready_x = sensor_x;
            ready_y = sensor_y;
         end
         if (sensor_data_ready && prev_ready) wide_pulse++;
         prev_cs = spi_cs_n; prev_sclk = spi_sclk; prev_busy = busy; prev_ready = sensor_data_ready;
         // Result bits 9..20 carry the conversion; everything else is noise.
         spi_miso = (!spi_cs_n && k >= 9 && k <= 20) ? cur_val[20 - k] : 1'($urandom);
      end
   end

   logic [9:0] exp_x = '0, exp_y = '0;

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_ready(input int bound, output bit ok);
      int start = ready_count;
      int i = 0;
      while (ready_count == start && i < bound) begin tick(); i++; end
      ok = (ready_count != start);
      if (!ok) check_val("ready_timeout", 0, 1);
   endtask

   task automatic check_pub(input logic [23:0] pair, input bit chk_period);
      bit ok;
      wait_ready(1500, ok);
      if (ok) begin
         exp_x = 10'(pair[23:12] >> 2);
         exp_y = 10'(pair[11:0] >> 2);
         check_val("pub_x", ready_x, exp_x);
         check_val("pub_y", ready_y, exp_y);
         check_val("latency", ready_cyc - t_cs_x, LAT);
         check_val("cmd_x", last_cmd_x, 8'hD0);
         check_val("cmd_y", last_cmd_y, 8'h90);
         check_val("rises_x", last_rise_x, 24);
         check_val("rises_y", last_rise_y, 24);
         check_val("gap", last_gap, CLK_DIV);
         check_val("pulse_len", sensor_data_ready, 0);
         if (chk_period) check_val("period", ready_cyc - prev_ready_cyc, PERIOD);
      end
   endtask

   logic [23:0] pairs[$];
   logic [23:0] p1, p2, pn;
   int st, rc, n, bfc;

   initial begin
      tick(3);
      check_val("rst_cs_n", spi_cs_n, 1);
      check_val("rst_sclk", spi_sclk, 0);
      check_val("rst_mosi", spi_mosi, 0);
      check_val("rst_x", sensor_x, 0);
      check_val("rst_y", sensor_y, 0);
      check_val("rst_ready", sensor_data_ready, 0);
      check_val("rst_busy", busy, 0);
      reset = 1'b0;
      enable = 1'b1;
      tick(300);
      check_val("penup_sclk_rises", rise_total, 0);
      check_val("penup_cs_falls", cs_fall_count, 0);

      // Back-to-back samples with the pen held down
      pairs = '{24'hFFFFFF, 24'h000000, {12'hABC, 12'h123}};
      for (int i = 0; i < 5; i++) pairs.push_back(24'($urandom));
      foreach (pairs[i]) adc_q.push_back(pairs[i]);
      pen_irq_n = 1'b0;
      for (int i = 0; i < pairs.size(); i++) check_pub(pairs[i], i > 0);
      pen_irq_n = 1'b1;
      tick(200);

      // Pen lifted during the Y frame
      p1 = 24'($urandom);
      adc_q.push_back(p1);
      st = cs_fall_count; rc = ready_count;
      pen_irq_n = 1'b0;
      n = 0;
      while (!(cs_fall_count >= st + 2 && k >= 5) && n < 3000) begin tick(); n++; end
      check_val("wait_y_shift", n < 3000, 1);
      pen_irq_n = 1'b1;
      bfc = busy_fall_cyc;
      n = 0;
      while (busy_fall_cyc == bfc && n < 2000) begin tick(); n++; end
      check_val("wait_busy_fall", n < 2000, 1);
      bfc = busy_fall_cyc;
      pn = 24'($urandom);
      adc_q.push_back(pn);
      pen_irq_n = 1'b0;
      check_val("lift_no_ready", ready_count - rc, 0);
      check_val("lift_rises_y", last_rise_y, 24);
      check_val("lift_hold_x", sensor_x, exp_x);
      check_val("lift_hold_y", sensor_y, exp_y);
      check_pub(pn, 1'b0);
      check_val("lift_wait_gap", t_cs_x - bfc, POLL + 1);

      // Reset in the middle of the X frame
      p1 = 24'($urandom);
      p2 = 24'($urandom);
      adc_q.push_back(p1);
      adc_q.push_back(p2);
      st = cs_fall_count; rc = ready_count;
      n = 0;
      while (!(cs_fall_count >= st + 1 && k >= 12) && n < 3000) begin tick(); n++; end
      check_val("wait_x_bit12", n < 3000, 1);
      reset = 1'b1;
      #1;
      check_val("arst_cs_n", spi_cs_n, 1);
      check_val("arst_sclk", spi_sclk, 0);
      check_val("arst_mosi", spi_mosi, 0);
      check_val("arst_busy", busy, 0);
      check_val("arst_x", sensor_x, 0);
      exp_x = '0; exp_y = '0;
      tick(3);
      reset = 1'b0;
      check_pub(p2, 1'b0);
      check_val("no_stale_publish", ready_count - rc, 1);

      // Enable low while the pen stays down
      enable = 1'b0;
      st = cs_fall_count;
      tick(500);
      check_val("disabled_cs_falls", cs_fall_count - st, 0);
      check_val("disabled_cs_n", spi_cs_n, 1);
      check_val("disabled_busy", busy, 0);
      check_val("ready_width", wide_pulse, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/touch_adc_reader.md
Name: touch_adc_reader

Overview:
- SPI master that polls a resistive-touch ADC (XPT2046-class) while the pen is down and produces the raw sensor sample stream.
- Drives the sensor-side interface (sensor_x, sensor_y, sensor_data_ready) consumed by the touch sensor capture stage.
- Each sample is one X frame followed by one Y frame. The 12-bit results are truncated to 10 bits and published with a single-cycle ready pulse.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal minimum is 2.
- POLL_CYCLES, 50000: idle clk cycles between the end of one sample sequence and the next pen check.
- CMD_X, 8'hD0: ADC command byte for the X conversion.
- CMD_Y, 8'h90: ADC command byte for the Y conversion.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  polling enable
- pen_irq_n  in  1  ADC pen-down flag, active low, asynchronous to clk
- spi_miso  in  1  ADC serial data out
- spi_sclk  out  1  SPI clock, mode 0, idles low
- spi_cs_n  out  1  ADC chip select, active low
- spi_mosi  out  1  command serial data
- sensor_x  out  10  last published X sample
- sensor_y  out  10  last published Y sample
- sensor_data_ready  out  1  one-cycle pulse: sensor_x/sensor_y updated this cycle
- busy  out  1  SPI sequence in progress

Behaviour:
- Reset is asynchronous and active-high; clock is clk. On reset, outputs take these values immediately, and the FSM goes to IDLE with all counters cleared:
  - spi_cs_n=1, spi_sclk=0, spi_mosi=0
  - sensor_x=0, sensor_y=0, sensor_data_ready=0, busy=0
- pen_irq_n passes through a 2-FF synchronizer; "pen down" means the synchronized value is 0.
- All outputs are registered.
- FSM states: IDLE, SETUP, SHIFT, GAP, PUBLISH, WAIT.
- IDLE: if enable=1 and pen down, go to SETUP for the X frame; spi_cs_n falls on that edge and busy rises. Otherwise stay.
- SETUP: lasts CLK_DIV cycles, with spi_cs_n=0, spi_sclk=0 and spi_mosi = bit 7 of the frame command.
- SHIFT: 24 bits, k=0..23. Each bit is CLK_DIV cycles with SCLK low, then CLK_DIV cycles with SCLK high.
  - spi_mosi changes only when SCLK goes low: cmd[7-k] for k=0..7, and 0 for k≥8.
  - spi_miso is sampled on the clk edge that raises SCLK. Bits k=9..20 form result[11:0], MSB first. All other sampled bits are ignored.
- GAP: spi_cs_n=1 and spi_sclk=0 for CLK_DIV cycles. After the X frame, go to SETUP for the Y frame; after the Y frame, go to PUBLISH.
- Frame length is 49*CLK_DIV cycles with cs_n low, plus CLK_DIV cycles of GAP.
- PUBLISH: lasts 1 cycle and busy falls.
  - If pen down and enable=1: sensor_x=resX[11:2], sensor_y=resY[11:2], sensor_data_ready=1 for exactly this cycle.
  - Otherwise the sample is discarded: no pulse, and sensor_x/sensor_y hold their values.
- Latency: sensor_data_ready rises exactly 100*CLK_DIV cycles after the edge that first drove spi_cs_n low.
- WAIT: counts POLL_CYCLES cycles, then goes to IDLE. When the pen stays down, the ready-pulse period is 100*CLK_DIV + POLL_CYCLES + 1 cycles.
- Pen lift or enable deassert mid-sequence: the SPI frames are never aborted. The Y frame completes and the sample is discarded in PUBLISH.
- sensor_x/sensor_y change only in a PUBLISH cycle that pulses ready. They are never partially updated.
- Reset mid-frame: the reset values apply immediately. After release, the captured partial result is never published; a full new sequence is required.
- Counter widths: sized with $clog2 of CLK_DIV, 24 and POLL_CYCLES+1. There is no wrap-around between states.

Test Plan:
- Reset with CLK_DIV=2 -> cs_n=1, sclk=0, mosi=0, x=y=0, ready=0, busy=0; no SCLK edges while pen_irq_n=1.
- Pen down, MISO model returns X=0xABC, Y=0x123 (CLK_DIV=2):
  - MOSI captures 0xD0 then 0x90.
  - Exactly 24 SCLK rises per frame, and cs_n is high for 2 clk between frames.
  - ready is a 1-cycle pulse 200 clk after the first cs_n fall, with sensor_x=0x2AF and sensor_y=0x048.
- Pen held down, POLL_CYCLES=100, CLK_DIV=2 -> consecutive ready pulses exactly 301 clk apart.
- Pen released during Y frame SHIFT -> Y frame completes normally, no ready pulse, sensor_x/y keep their previous values, FSM passes through WAIT.
- Reset pulsed at X-frame bit 12 -> cs_n=1 and sclk=0 asynchronously; after release with pen down, a fresh X frame starts with no stale publish.
- MISO all-ones -> x=y=0x3FF; MISO all-zeros -> x=y=0x000; enable=0 with pen down -> cs_n stays 1 indefinitely.
